joy_db15_tx: RTL and testbench

Device-side responder for the SNAC DB15 serial joystick link. It emulates the parallel-in/serial-out shift chain that the `joy_db15` reader polls through `JOY_LOAD`, `JOY_CLK` and `JOY_DATA`. It snapshots two players' button vectors while the reader holds load low, then presents one bit per reader clock, so `joy_db15` and its reader logic can be exercised in loopback on the user port. It lives beside `joy_db15` in the controller support area and runs entirely on `clk_sys`.

---
 rtl/joy_db15_pkg.sv | 6 +
 rtl/joy_db15_tx_if.sv | 14 +
 rtl/joy_db15_tx_sync_edge.sv | 25 ++
 rtl/joy_db15_tx.sv | 70 +++++++
 tb/tb_joy_db15_tx.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/joy_db15_pkg.sv
// joy_db15_pkg: shared constants and state type for the SNAC DB15 device-side responder.
package joy_db15_pkg;
   localparam int JOY_NBITS = 12;
   localparam int JOY_FRAME = 2 * JOY_NBITS;
   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} joy_tx_state_t;
endpackage

// File: rtl/joy_db15_tx_if.sv
// joy_db15_tx_if: button vectors plus the DB15 reader lines seen by the device-side responder.
interface joy_db15_tx_if import joy_db15_pkg::*; #(
   parameter int NBITS = JOY_NBITS
);
   logic [NBITS-1:0] joystick1;
   logic [NBITS-1:0] joystick2;
   logic             joy_clk;
   logic             joy_load;
   logic             joy_data;
   logic             busy;
   logic             frame_done;
   modport master (output joystick1, joystick2, joy_clk, joy_load, input joy_data, busy, frame_done);
   modport slave  (input joystick1, joystick2, joy_clk, joy_load, output joy_data, busy, frame_done);
endinterface

// File: rtl/joy_db15_tx_sync_edge.sv
// sync_edge: multi-flop synchroniser for an idle-high async line with rise/fall detect.
module sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);
   logic [STAGES-1:0] s;
   logic              q_d;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         s   <= '1;
         q_d <= 1'b1;
      end else begin
         s   <= {s[STAGES-2:0], d};
         q_d <= s[STAGES-1];
      end
   assign q    = s[STAGES-1];
   assign rise = q & ~q_d;
   assign fall = ~q & q_d;
endmodule

// File: rtl/joy_db15_tx.sv
// joy_db15_tx: emulates the DB15 parallel-in/serial-out chain polled by the joy_db15 reader.
// Snapshots both players while load is low, then shifts one bit per reader clock rise.
module joy_db15_tx import joy_db15_pkg::*; #(
   parameter int NBITS       = JOY_NBITS,
   parameter int SYNC_STAGES = 2
) (
   input logic          clk,
   input logic          reset,
   joy_db15_tx_if.slave bus
);
   localparam int FRAME = 2 * NBITS;
   localparam int CW    = $clog2(FRAME + 1);
   localparam logic [CW-1:0] LAST = CW'(FRAME - 1);
   localparam logic [CW-1:0] FULL = CW'(FRAME);
   joy_tx_state_t    state, state_n;
   logic [FRAME-1:0] shreg, shreg_n;
   logic [CW-1:0]    bit_cnt, bit_cnt_n;
   logic             clk_q, clk_rise, clk_fall;
   logic             load_q, load_rise, load_fall;
   logic             data_r, done_r, done_n, shift;
   sync_edge #(.STAGES(SYNC_STAGES)) u_clk_sync (
      .clk(clk), .reset(reset), .d(bus.joy_clk), .q(clk_q), .rise(clk_rise), .fall(clk_fall)
   );
   sync_edge #(.STAGES(SYNC_STAGES)) u_load_sync (
      .clk(clk), .reset(reset), .d(bus.joy_load), .q(load_q), .rise(load_rise), .fall(load_fall)
   );
   // Load has priority over a coincident clock rise, so the snapshot is never shifted early.
   always_comb begin
      state_n   = state;
      shreg_n   = shreg;
      bit_cnt_n = bit_cnt;
      done_n    = 1'b0;
      shift     = clk_rise && (state == SHIFT || state == DONE);
      if (!load_q) begin
         state_n   = LOAD;
         shreg_n   = ~{bus.joystick2, bus.joystick1};
         bit_cnt_n = '0;
      end else begin
         if (state == LOAD) state_n = SHIFT;
         if (shift) begin
            shreg_n   = {1'b1, shreg[FRAME-1:1]};
            bit_cnt_n = (bit_cnt == FULL) ? bit_cnt : bit_cnt + 1'b1;
            if (state == SHIFT && bit_cnt == LAST) begin
               state_n = DONE;
               done_n  = 1'b1;
            end
         end
      end
   end
   // joy_data follows the next shift value so the pin moves with the shift register itself.
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state   <= IDLE;
         shreg   <= '1;
         bit_cnt <= '0;
         data_r  <= 1'b1;
         done_r  <= 1'b0;
      end else begin
         state   <= state_n;
         shreg   <= shreg_n;
         bit_cnt <= bit_cnt_n;
         data_r  <= (state_n == IDLE) | shreg_n[0];
         done_r  <= done_n;
      end
   assign bus.joy_data   = data_r;
   assign bus.busy       = (state == SHIFT);
   assign bus.frame_done = done_r;
   assert property (@(posedge clk) disable iff (reset)
      !(clk_rise && clk_fall) && !(load_rise && load_fall) && (!clk_rise || clk_q) && (!load_rise || load_q));
endmodule

// File: tb/tb_joy_db15_tx.sv
// tb_joy_db15_tx: acts as the joy_db15 reader and checks frames against a bit-order model.
`timescale 1ns/1ps
module tb_joy_db15_tx;
   import joy_db15_pkg::*;
   localparam int N = JOY_NBITS;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   done_cnt = 0;
   joy_db15_tx_if #(.NBITS(N)) bus ();
   joy_db15_tx #(.NBITS(N), .SYNC_STAGES(2)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   always @(negedge clk) if (bus.frame_done === 1'b1) done_cnt++;
   initial begin
      #5_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end
   // Reader sees player 1 bit 0 first, active low; past the frame it sees released (1) bits.
   function automatic logic exp_bit(input logic [N-1:0] a, input logic [N-1:0] b, input int i);
      logic q[$];
      for (int k = 0; k < N; k++) q.push_back(~a[k]);
      for (int k = 0; k < N; k++) q.push_back(~b[k]);
      return (i < q.size()) ? q[i] : 1'b1;
   endfunction
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask
   task automatic do_load();
      bus.joy_load = 1'b0;
      cyc(6);
      bus.joy_load = 1'b1;
      cyc(6);
   endtask
   task automatic rd_bit(output logic b);
      bus.joy_clk = 1'b0;
      cyc(6);
      @(negedge clk);
      b = bus.joy_data;
      cyc(1);
      bus.joy_clk = 1'b1;
      cyc(6);
   endtask
   task automatic read_bits(input int n, output logic [31:0] bits);
      logic b;
      bits = '1;
      for (int i = 0; i < n; i++) begin
         rd_bit(b);
         bits[i] = b;
      end
   endtask
   task automatic test_reset();
      @(negedge clk);
      checks++;
      if (bus.joy_data !== 1'b1) begin errors++; $display("FAIL reset_data got %b want 1", bus.joy_data); end
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
      checks++;
      if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.frame_done); end
      cyc(1);
      reset = 1'b0;
      for (int i = 0; i < 40; i++) begin
         bus.joy_clk = 1'b0;
         cyc(12);
         bus.joy_clk = 1'b1;
         cyc(13);
      end
      @(negedge clk);
      checks++;
      if (done_cnt !== 0) begin errors++; $display("FAIL idle_done_count got %0d want 0", done_cnt); end
      checks++;
      if (bus.joy_data !== 1'b1) begin errors++; $display("FAIL idle_data got %b want 1", bus.joy_data); end
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", bus.busy); end
   endtask
   task automatic test_frame_fixed();
      logic [31:0] got;
      int d0;
      bus.joystick1 = 12'h005;
      bus.joystick2 = 12'h800;
      d0 = done_cnt;
      do_load();
      checks++;
      if (bus.busy !== 1'b1) begin errors++; $display("FAIL fixed_busy_on got %b want 1", bus.busy); end
      read_bits(24, got);
      cyc(6);
      for (int i = 0; i < 24; i++) begin
         checks++;
         if (got[i] !== exp_bit(12'h005, 12'h800, i))
            begin errors++; $display("FAIL fixed_bit%0d got %b want %b", i, got[i], exp_bit(12'h005, 12'h800, i)); end
      end
      checks++;
      if (done_cnt - d0 !== 1) begin errors++; $display("FAIL fixed_done_pulses got %0d want 1", done_cnt - d0); end
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL fixed_busy_off got %b want 0", bus.busy); end
   endtask
   task automatic test_overrun();
      logic [31:0] got;
      logic [N-1:0] a, b;
      int d0;
      a = N'($urandom);
      b = N'($urandom);
      bus.joystick1 = a;
      bus.joystick2 = b;
      d0 = done_cnt;
      do_load();
      read_bits(30, got);
      cyc(6);
      for (int i = 0; i < 30; i++) begin
         checks++;
         if (got[i] !== exp_bit(a, b, i))
            begin errors++; $display("FAIL overrun_bit%0d got %b want %b", i, got[i], exp_bit(a, b, i)); end
      end
      checks++;
      if (done_cnt - d0 !== 1) begin errors++; $display("FAIL overrun_done_pulses got %0d want 1", done_cnt - d0); end
   endtask
   task automatic test_abort();
      logic [31:0] got;
      int d0;
      bus.joystick1 = N'($urandom);
      bus.joystick2 = N'($urandom);
      d0 = done_cnt;
      do_load();
      read_bits(10, got);
      bus.joystick1 = 12'hFFF;
      bus.joystick2 = 12'h000;
      do_load();
      checks++;
      if (done_cnt !== d0) begin errors++; $display("FAIL abort_no_done got %0d want %0d", done_cnt, d0); end
      read_bits(24, got);
      cyc(6);
      for (int i = 0; i < 24; i++) begin
         checks++;
         if (got[i] !== exp_bit(12'hFFF, 12'h000, i))
            begin errors++; $display("FAIL abort_bit%0d got %b want %b", i, got[i], exp_bit(12'hFFF, 12'h000, i)); end
      end
      checks++;
      if (done_cnt - d0 !== 1) begin errors++; $display("FAIL abort_done_pulses got %0d want 1", done_cnt - d0); end
   endtask
   task automatic test_collision();
      logic [31:0] got;
      logic [N-1:0] a, b;
      bus.joystick1 = N'($urandom);
      bus.joystick2 = N'($urandom);
      do_load();
      read_bits(3, got);
      a = N'($urandom);
      b = N'($urandom);
      bus.joystick1 = a;
      bus.joystick2 = b;
      bus.joy_clk = 1'b0;
      cyc(6);
      bus.joy_load = 1'b0;
      bus.joy_clk = 1'b1;
      cyc(6);
      bus.joy_load = 1'b1;
      cyc(6);
      read_bits(24, got);
      for (int i = 0; i < 24; i++) begin
         checks++;
         if (got[i] !== exp_bit(a, b, i))
            begin errors++; $display("FAIL collide_bit%0d got %b want %b", i, got[i], exp_bit(a, b, i)); end
      end
   endtask
   task automatic test_async_reset();
      logic [31:0] got;
      logic [N-1:0] a, b;
      int d0;
      a = N'($urandom) | 12'h080;
      b = N'($urandom);
      bus.joystick1 = a;
      bus.joystick2 = b;
      do_load();
      read_bits(7, got);
      @(negedge clk);
      checks++;
      if (bus.joy_data !== 1'b0) begin errors++; $display("FAIL areset_bit7 got %b want 0", bus.joy_data); end
      #1 reset = 1'b1;
      #1;
      checks++;
      if (bus.joy_data !== 1'b1) begin errors++; $display("FAIL areset_data got %b want 1", bus.joy_data); end
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL areset_busy got %b want 0", bus.busy); end
      cyc(2);
      reset = 1'b0;
      cyc(2);
      d0 = done_cnt;
      read_bits(30, got);
      cyc(6);
      checks++;
      if (got[29:0] !== 30'h3FFF_FFFF) begin errors++; $display("FAIL areset_ignored got %h want 3fffffff", got[29:0]); end
      checks++;
      if (done_cnt !== d0) begin errors++; $display("FAIL areset_no_done got %0d want %0d", done_cnt, d0); end
      a = N'($urandom);
      b = N'($urandom);
      bus.joystick1 = a;
      bus.joystick2 = b;
      do_load();
      read_bits(24, got);
      for (int i = 0; i < 24; i++) begin
         checks++;
         if (got[i] !== exp_bit(a, b, i))
            begin errors++; $display("FAIL areset_recover_bit%0d got %b want %b", i, got[i], exp_bit(a, b, i)); end
      end
   endtask
   task automatic test_loopback();
      logic [31:0] got;
      logic [N-1:0] a, b, r1, r2;
      int d0;
      d0 = done_cnt;
      for (int f = 0; f < 100; f++) begin
         a = N'($urandom);
         b = N'($urandom);
         bus.joystick1 = a;
         bus.joystick2 = b;
         do_load();
         read_bits(JOY_FRAME, got);
         for (int i = 0; i < N; i++) begin
            r1[i] = ~got[i];
            r2[i] = ~got[N + i];
         end
         checks++;
         if (r1 !== a) begin errors++; $display("FAIL loop%0d_joy1 got %h want %h", f, r1, a); end
         checks++;
         if (r2 !== b) begin errors++; $display("FAIL loop%0d_joy2 got %h want %h", f, r2, b); end
      end
      cyc(6);
      checks++;
      if (done_cnt - d0 !== 100) begin errors++; $display("FAIL loop_done_pulses got %0d want 100", done_cnt - d0); end
   endtask
   initial begin
      bus.joystick1 = '0;
      bus.joystick2 = '0;
      bus.joy_clk   = 1'b1;
      bus.joy_load  = 1'b1;
      cyc(3);
      test_reset();
      test_frame_fixed();
      test_overrun();
      test_abort();
      test_collision();
      test_async_reset();
      test_loopback();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
